// File: rtl/lfsr_sched.sv
// lfsr_sched: round-robin arbiter that shares one 8-bit Fibonacci LFSR
// between NREQ requesters and streams seeded bursts over valid/ready.
module lfsr_sched #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] seed,
    input  logic [8*NREQ-1:0] tap,
    input  logic [4*NREQ-1:0] len,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [7:0]    tap_q, tap_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          gnt_en_q, gnt_en_d;
    logic          done_q, done_d;

    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic [7:0]    seed_sel, tap_sel;
    logic [3:0]    len_sel;
    logic          grant, hs, last;
    logic [7:0]    lfsr_step;

    // Reverse scan so the lowest offset from ptr+1 is assigned last and wins
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (req[j]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

    assign seed_sel  = seed[8*int'(pick_idx) +: 8];
    assign tap_sel   = tap[8*int'(pick_idx) +: 8];
    assign len_sel   = len[4*int'(pick_idx) +: 4];
    assign grant     = (state_q == IDLE) && pick_vld;
    assign hs        = (state_q == RUN) && dout_ready;
    assign last      = hs && (cnt_q == 4'd1);
    assign lfsr_step = {lfsr_q[6:0], ^(lfsr_q & tap_q)};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (grant && len_sel != 4'd0) state_d = RUN;
            RUN:  if (last) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q   <= 8'h00;
            tap_q    <= 8'h00;
            cnt_q    <= 4'd0;
            owner_q  <= '0;
            ptr_q    <= IW'(NREQ - 1);
            gnt_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            tap_q    <= tap_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            gnt_en_q <= gnt_en_d;
            done_q   <= done_d;
        end
    end

    // gnt stays up through the done cycle and drops after it unless regranted
    always_comb begin
        lfsr_d   = lfsr_q;
        tap_d    = tap_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        gnt_en_d = gnt_en_q;
        done_d   = 1'b0;
        if (grant) begin
            lfsr_d   = seed_sel;
            tap_d    = tap_sel;
            cnt_d    = len_sel;
            owner_d  = pick_idx;
            ptr_d    = pick_idx;
            gnt_en_d = 1'b1;
            done_d   = (len_sel == 4'd0);
        end else if (state_q == IDLE) begin
            gnt_en_d = 1'b0;
        end else if (hs) begin
            lfsr_d = lfsr_step;
            cnt_d  = cnt_q - 4'd1;
            done_d = last;
        end
    end

    always_comb begin
        gnt        = gnt_en_q ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_q) : '0;
        dout       = lfsr_q;
        dout_valid = (state_q == RUN);
        done       = done_q;
    end

endmodule
